// File: rtl/data_out_8_to_64.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | data_out_8_to_64 : assembles eight strobed bytes, MSB first, into  |
// |                    one registered 64-bit word with a done pulse.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module data_out_8_to_64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data_8,
  input  logic        data_out_enable,
  output logic [63:0] data_64,
  output logic        data_out_done
);

  localparam logic [2:0] c_LAST_BYTE = 3'd7;

  logic        r_en_d;
  logic [2:0]  r_cnt;
  logic [55:0] r_buf;
  logic [63:0] r_data_64;
  logic        r_done;
  logic        w_capture;

  // A strobe of any length yields exactly one capture on its first high cycle.
  assign w_capture = data_out_enable & ~r_en_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_en_d    <= 1'b0;
      r_cnt     <= 3'd0;
      r_buf     <= 56'd0;
      r_data_64 <= 64'd0;
      r_done    <= 1'b0;
    end else begin
      r_en_d <= data_out_enable;
      r_done <= 1'b0;
      if (w_capture) begin
        r_buf <= {r_buf[47:0], data_8};
        if (r_cnt == c_LAST_BYTE) begin
          r_data_64 <= {r_buf, data_8};
          r_done    <= 1'b1;
          r_cnt     <= 3'd0;
        end else begin
          r_cnt <= r_cnt + 3'd1;
        end
      end
    end
  end

  assign data_64       = r_data_64;
  assign data_out_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_data_out_8_to_64.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_data_out_8_to_64 : testbench for data_out_8_to_64               |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_data_out_8_to_64;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data_8;
  logic        data_out_enable;
  logic [63:0] data_64;
  logic        data_out_done;

  int checks = 0;
  int failures = 0;
  int dut_done_cnt = 0;

  logic [7:0]  m_q[$];
  logic [63:0] m_word = 64'd0;
  logic        m_done = 1'b0;
  logic        m_prev_en = 1'b0;

  data_out_8_to_64 u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .data_8          (data_8),
    .data_out_enable (data_out_enable),
    .data_64         (data_64),
    .data_out_done   (data_out_done)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference: a rising strobe appends a byte; eight bytes form the word.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_word    = 64'd0;
      m_done    = 1'b0;
      m_prev_en = 1'b0;
    end else begin
      m_done = 1'b0;
      if (data_out_enable && !m_prev_en) begin
        m_q.push_back(data_8);
        if (m_q.size() == 8) begin
          for (int i = 0; i < 8; i++) m_word[63-8*i -: 8] = m_q[i];
          m_done = 1'b1;
          m_q.delete();
        end
      end
      m_prev_en = data_out_enable;
    end
    #1;
    checks++;
    if (data_64 !== m_word) begin
      failures++;
      $display("FAIL data_64 t=%0t actual=%h required=%h", $time, data_64, m_word);
    end
    checks++;
    if (data_out_done !== m_done) begin
      failures++;
      $display("FAIL done t=%0t actual=%b required=%b", $time, data_out_done, m_done);
    end
    if (data_out_done === 1'b1) dut_done_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
    @(negedge clk);
    data_8 = b;
    data_out_enable = 1'b1;
    repeat (hi - 1) @(negedge clk);
    @(negedge clk);
    data_out_enable = 1'b0;
    data_8 = 8'($urandom);
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic send_word(input logic [63:0] w, input int hi, input int lo);
    for (int i = 0; i < 8; i++) send_byte(w[63-8*i -: 8], hi, lo);
  endtask

  task automatic check_lit(input string name, input logic [63:0] w_exp,
                           input int done_base, input int done_exp);
    repeat (2) @(negedge clk);
    checks++;
    if (data_64 !== w_exp) begin
      failures++;
      $display("FAIL %s word actual=%h required=%h", name, data_64, w_exp);
    end
    checks++;
    if (dut_done_cnt - done_base != done_exp) begin
      failures++;
      $display("FAIL %s done_pulses actual=%0d required=%0d", name,
               dut_done_cnt - done_base, done_exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      data_out_enable = ~data_out_enable;
      data_8 = 8'($urandom);
      @(negedge clk);
    end
    data_out_enable = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    logic [63:0] w1, w2;
    rst_n = 1'b0;
    data_8 = 8'd0;
    data_out_enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (data_64 !== 64'd0 || data_out_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state actual=%h/%b required=0/0", data_64, data_out_done);
    end

    // Enable high while leaving reset counts as the first capture.
    base = dut_done_cnt;
    @(negedge clk);
    data_out_enable = 1'b1;
    @(negedge clk);
    data_out_enable = 1'b0;
    data_8 = 8'h5a;
    data_out_enable = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    data_out_enable = 1'b0;
    @(negedge clk);
    for (int i = 1; i < 8; i++) send_byte(8'(i), 1, 2);
    check_lit("release_capture", 64'h5a01020304050607, base, 1);

    do_reset(1);
    base = dut_done_cnt;
    w1 = 64'hd7a701a0c40427cb;
    for (int i = 0; i < 7; i++) send_byte(w1[63-8*i -: 8], 2, 4340);
    check_lit("word1_partial", 64'd0, base, 0);
    send_byte(w1[7:0], 2, 4340);
    check_lit("word1", 64'hd7a701a0c40427cb, base, 1);

    base = dut_done_cnt;
    w2 = 64'h464d749afa037423;
    for (int i = 0; i < 7; i++) send_byte(w2[63-8*i -: 8], 2, 2 + int'($urandom_range(0, 40)));
    check_lit("word2_hold", 64'hd7a701a0c40427cb, base, 0);
    send_byte(w2[7:0], 2, 3);
    check_lit("word2", 64'h464d749afa037423, base, 1);

    base = dut_done_cnt;
    send_word(64'h0102030405060708, 10, 3);
    check_lit("long_strobe", 64'h0102030405060708, base, 1);

    base = dut_done_cnt;
    send_word(64'hffeeddccbbaa9988, 1, 1);
    check_lit("fast_strobe", 64'hffeeddccbbaa9988, base, 1);

    send_byte(8'hde, 1, 2);
    send_byte(8'had, 1, 2);
    send_byte(8'hbe, 1, 2);
    do_reset(2);
    base = dut_done_cnt;
    check_lit("midword_reset_clear", 64'd0, base, 0);
    send_word(64'h1122334455667788, 2, 2);
    check_lit("midword_reset", 64'h1122334455667788, base, 1);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) do_reset(int'($urandom_range(1, 3)));
      send_byte(8'($urandom), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
    end
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
